reg_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one 8-bit enabled register (D/En/Q storage element clocked on `clk`) among several requesters. Each requester presents data and a request. The arbiter grants one requester at a time, drives the register's D and En for exactly one cycle, and acknowledges the winner. It sits between the requesting control blocks and the shared register instance. The register itself stays outside this block.

---
 rtl/reg_write_arbiter.sv | 101 ++++++++++
 tb/tb_reg_write_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester a 1-cycle write (D/En) into a shared register.
// Latency: req sampled in ARB at edge k -> reg_en/ack during cycle k+1; one write per 3 cycles max.
module reg_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int CW    = 8,
    localparam int OW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] din,
    output logic [N_REQ-1:0]   ack,
    output logic               reg_en,
    output logic [W-1:0]       reg_d,
    output logic [OW-1:0]      owner,
    output logic               busy,
    output logic [CW-1:0]      wr_count
);

    typedef enum logic [1:0] {
        S_ARB     = 2'd0,
        S_WRITE   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t           r_state;
    logic [OW-1:0]    r_ptr;
    logic [OW-1:0]    r_owner;
    logic [W-1:0]     r_data;
    logic [CW-1:0]    r_count;

    logic             w_found;
    logic [OW-1:0]    w_win;
    logic [W-1:0]     w_win_dat;
    logic [OW:0]      w_sum;
    logic [OW-1:0]    w_idx;
    logic [N_REQ-1:0] w_ack;

    // Search starts at r_ptr and wraps; the first requester found wins.
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_win_dat = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (OW+1)'(k);
            if (w_sum >= (OW+1)'(N_REQ))
                w_sum = w_sum - (OW+1)'(N_REQ);
            w_idx = w_sum[OW-1:0];
            if (!w_found && req[w_idx]) begin
                w_found   = 1'b1;
                w_win     = w_idx;
                w_win_dat = din[w_idx*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ARB;
            r_ptr   <= '0;
            r_owner <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_ARB: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_data  <= w_win_dat;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_ptr   <= (r_owner == OW'(N_REQ-1)) ? '0 : r_owner + OW'(1);
                    r_count <= r_count + CW'(1);
                    r_state <= S_RECOVER;
                end
                S_RECOVER: r_state <= S_ARB;
                default:   r_state <= S_ARB;
            endcase
        end
    end

    // Strobes decode from state so an async reset drops them without a clock.
    always_comb begin
        w_ack = '0;
        if (r_state == S_WRITE)
            w_ack[r_owner] = 1'b1;
    end

    assign ack      = w_ack;
    assign reg_en   = (r_state == S_WRITE);
    assign reg_d    = r_data;
    assign owner    = r_owner;
    assign busy     = (r_state != S_ARB);
    assign wr_count = r_count;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected grants are queued as requests are driven.
module tb_reg_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        int         idx;
        logic [7:0] dat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] din = '0;
    logic [N*W-1:0] din_next = '0;
    logic [N-1:0]   ack;
    logic           reg_en;
    logic [W-1:0]   reg_d;
    logic [1:0]     owner;
    logic           busy;
    logic [7:0]     wr_count;

    exp_t           sb[$];
    int             n_tests = 0;
    int             n_fail  = 0;
    int             n_pop   = 0;
    int             cyc     = 0;
    int             last_en = -1;
    bit             auto_drop = 0;
    bit             auto_rr   = 0;
    bit             chk_period = 0;
    logic [N-1:0]   reraise = '0;
    logic [N-1:0]   prev_ack = '0;
    logic [N-1:0]   acked = '0;

    reg_write_arbiter #(.N_REQ(N), .W(W), .CW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .din      (din),
        .ack      (ack),
        .reg_en   (reg_en),
        .reg_d    (reg_d),
        .owner    (owner),
        .busy     (busy),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] dat);
        exp_t e;
        e.idx = idx;
        e.dat = dat;
        sb.push_back(e);
    endtask

    task automatic set_din(input int i, input logic [7:0] v);
        din[i*W +: W]      = v;
        din_next[i*W +: W] = v;
    endtask

    // One clock; din_next lands 1 ns after the edge, outputs are sampled 2 ns after it.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        din = din_next;
        #1;
        if (reg_en) begin
            if (sb.size() == 0) begin
                chk("unexp_wr", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("owner", 32'(owner), 32'(e.idx));
                chk("reg_d", 32'(reg_d), 32'(e.dat));
                chk("ack", 32'(ack), 32'd1 << e.idx);
            end
            chk("ack_gap", 32'(prev_ack), 32'd0);
            if (chk_period && last_en >= 0)
                chk("period", 32'(cyc - last_en), 32'd3);
            last_en = cyc;
            n_pop++;
            acked = acked | ack;
        end else begin
            chk("ack_idle", 32'(ack), 32'd0);
        end
        prev_ack = ack;
        req = req | reraise;
        reraise = '0;
        if (auto_drop) begin
            req = req & ~ack;
            if (auto_rr)
                reraise = ack;
        end
    endtask

    task automatic wait_grants(input int n);
        int tgt;
        int bud;
        tgt = n_pop + n;
        bud = n * 4 + 8;
        while (n_pop < tgt && bud > 0) begin
            step();
            bud--;
        end
        chk("timeout", 32'(n_pop), 32'(tgt));
    endtask

    task automatic do_reset();
        req = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        last_en = -1;
        prev_ack = '0;
    endtask

    task automatic run_writes(input int n);
        set_din(0, 8'h3C);
        for (int i = 0; i < n; i++)
            push(0, 8'h3C);
        auto_drop = 1; auto_rr = 1; chk_period = 1; last_en = -1;
        req = 4'b0001;
        wait_grants(n);
        auto_rr = 0; auto_drop = 0; chk_period = 0; reraise = '0; req = '0;
        step();
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with all requests active
        set_din(0, 8'h10); set_din(1, 8'h21); set_din(2, 8'h32); set_din(3, 8'h43);
        rst_n = 1'b0;
        req = 4'b1111;
        repeat (3) step();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_en", 32'(reg_en), 32'd0);
        chk("rst_d", 32'(reg_d), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(wr_count), 32'd0);
        rst_n = 1'b1;
        push(0, 8'h10);
        wait_grants(1);
        req = '0;
        step();
        step();

        // Single write from requester 2
        do_reset();
        set_din(2, 8'hA5);
        req = 4'b0100;
        push(2, 8'hA5);
        step();
        chk("lat_en", 32'(reg_en), 32'd1);
        chk("wr_busy", 32'(busy), 32'd1);
        req = '0;
        step();
        chk("rec_busy", 32'(busy), 32'd1);
        chk("rec_en", 32'(reg_en), 32'd0);
        step();
        chk("arb_busy", 32'(busy), 32'd0);
        chk("cnt_one", 32'(wr_count), 32'd1);

        // Round-robin under saturation
        do_reset();
        set_din(0, 8'h10); set_din(1, 8'h21); set_din(2, 8'h32); set_din(3, 8'h43);
        push(0, 8'h10); push(1, 8'h21); push(2, 8'h32); push(3, 8'h43); push(0, 8'h10);
        auto_drop = 1; auto_rr = 1; chk_period = 1; last_en = -1;
        req = 4'b1111;
        wait_grants(5);
        auto_rr = 0; auto_drop = 0; chk_period = 0; reraise = '0; req = '0;
        step();
        step();
        chk("cnt_rr", 32'(wr_count), 32'd5);

        // Pointer wrap and skip of an idle requester
        do_reset();
        acked = '0;
        auto_drop = 1;
        push(2, 8'h32); push(0, 8'h10); push(1, 8'h21);
        req = 4'b0100;
        wait_grants(1);
        req = 4'b0011;
        wait_grants(2);
        auto_drop = 0;
        step();
        step();
        chk("rq3_never", 32'(acked[3]), 32'd0);

        // Data captured at grant, later din changes ignored
        do_reset();
        set_din(1, 8'h11);
        din_next[1*W +: W] = 8'hFF;
        req = 4'b0010;
        push(1, 8'h11);
        wait_grants(1);
        chk("d_hold", 32'(reg_d), 32'h11);
        req = '0;
        step();
        step();
        set_din(1, 8'h21);

        // Counter wrap, then async reset in the middle of a write
        do_reset();
        run_writes(255);
        chk("cnt_ff", 32'(wr_count), 32'hFF);
        run_writes(1);
        chk("cnt_wrap", 32'(wr_count), 32'h00);
        run_writes(255);
        chk("cnt_ff2", 32'(wr_count), 32'hFF);
        set_din(0, 8'h5A);
        req = 4'b0001;
        push(0, 8'h5A);
        wait_grants(1);
        rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(reg_en), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_cnt", 32'(wr_count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        #1;
        rst_n = 1'b1;
        req = '0;
        prev_ack = '0;
        step();
        chk("post_cnt", 32'(wr_count), 32'd0);
        chk("post_en", 32'(reg_en), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
